// File: rtl/zx_mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zx_mmu_pkg
// Brief    : Port decode constants, fixed page numbers, reset values and the
//            physical page helper shared by the zx_mmu memory mapper.
// Revision : 1.0 - initial release
// ============================================================================
package zx_mmu_pkg;

  localparam logic [15:0] c_port_7ffd_mask = 16'h8002;
  localparam logic [15:0] c_port_7ffd_val  = 16'h0000;
  localparam logic [15:0] c_port_fe_mask   = 16'h0001;
  localparam logic [15:0] c_port_fe_val    = 16'h0000;
  localparam logic [15:0] c_port_1ffd_mask = 16'hF002;
  localparam logic [15:0] c_port_1ffd_val  = 16'h1000;

  localparam logic [5:0] c_ram_screen0 = 6'd5;
  localparam logic [5:0] c_ram_screen1 = 6'd7;
  localparam logic [5:0] c_ram_slot2   = 6'd2;

  localparam logic [4:0] c_rst_ram_sel    = 5'd0;
  localparam logic       c_rst_rom_sel    = 1'b0;
  localparam logic       c_rst_screen     = 1'b0;
  localparam logic       c_rst_cfg_locked = 1'b0;
  localparam logic [2:0] c_rst_border     = 3'd0;
  localparam logic [2:0] c_rst_plus3      = 3'd0;

  // ROM pages sit at the bottom of the physical array, RAM follows them.
  function automatic logic [7:0] phys_page(input logic is_rom,
                                           input logic [5:0] idx,
                                           input int rom_pages = 2);
    logic [7:0] w_base;
    w_base = is_rom ? 8'd0 : 8'(rom_pages);
    return w_base + {2'b00, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/zx_io_edge.sv
`default_nettype none
// ============================================================================
// Module   : zx_io_edge
// Brief    : Registers an I/O strobe and emits a single-cycle event on its
//            rising edge, however long the strobe is held.
// Revision : 1.0 - initial release
// ============================================================================
module zx_io_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe,
  output logic edge_evt
);

  logic r_strobe_q;

  always_ff @(posedge clock) begin
    if (!reset_n) r_strobe_q <= 1'b0;
    else          r_strobe_q <= strobe;
  end

  // A strobe still high when reset lifts counts as a fresh edge.
  assign edge_evt = strobe & ~r_strobe_q;

endmodule
`default_nettype wire

// File: rtl/zx_mmu.sv
`default_nettype none
// ============================================================================
// Module   : zx_mmu
// Brief    : Spectrum-128 style memory mapper: paged ROM/RAM slots, shadow
//            screen select and border port. Optional macro ZX_MMU_PLUS3_EN
//            adds the +3 1FFD port (upper ROM bit and special RAM mode).
// Revision : 1.0 - initial release
// ============================================================================
module zx_mmu
  import zx_mmu_pkg::*;
#(
  parameter int ROM_PAGES = 2,
  parameter int RAM_PAGES = 8,
  parameter int PHYS_W    = 18
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_wren,
  input  logic [15:0]       io_addr,
  input  logic [7:0]        io_data,
  input  logic              io_wren,
  input  logic [12:0]       vid_addr,
  output logic [PHYS_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [PHYS_W-1:0] vid_mem_addr,
  output logic [2:0]        border,
  output logic              cfg_locked
);

  localparam bit c_ram16 = (RAM_PAGES >= 16);
  localparam bit c_ram32 = (RAM_PAGES == 32);
  localparam bit c_rom4  = (ROM_PAGES == 4);

  logic       w_io_evt;
  logic       w_hit_7ffd;
  logic       w_hit_fe;
  logic       w_hit_1ffd;
  logic [4:0] r_ram_sel;
  logic       r_rom_lo;
  logic       r_screen;
  logic       r_cfg_locked;
  logic [2:0] r_border;
  logic       w_rom_hi;
  logic       w_special;
  logic [1:0] w_special_sel;
  logic [1:0] w_rom_sel;
  logic       w_is_rom;
  logic [5:0] w_idx;
  logic [7:0] w_page;
  logic [7:0] w_vid_page;
  logic [21:0] w_full_addr;
  logic [21:0] w_full_vid;

  zx_io_edge u_io_edge (
    .clock    (clock),
    .reset_n  (reset_n),
    .strobe   (io_wren),
    .edge_evt (w_io_evt)
  );

  assign w_hit_7ffd = ((io_addr & c_port_7ffd_mask) == c_port_7ffd_val);
  assign w_hit_fe   = ((io_addr & c_port_fe_mask)   == c_port_fe_val);
  assign w_hit_1ffd = ((io_addr & c_port_1ffd_mask) == c_port_1ffd_val);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ram_sel    <= c_rst_ram_sel;
      r_rom_lo     <= c_rst_rom_sel;
      r_screen     <= c_rst_screen;
      r_cfg_locked <= c_rst_cfg_locked;
      r_border     <= c_rst_border;
    end else begin
      if (w_io_evt && w_hit_7ffd && !r_cfg_locked) begin
        r_ram_sel[2:0] <= io_data[2:0];
        if (c_ram16) r_ram_sel[3] <= io_data[6];
        if (c_ram32) r_ram_sel[4] <= io_data[7];
        r_screen     <= io_data[3];
        r_rom_lo     <= io_data[4];
        r_cfg_locked <= io_data[5];
      end
      if (w_io_evt && w_hit_fe) r_border <= io_data[2:0];
    end
  end

`ifdef ZX_MMU_PLUS3_EN
  logic [2:0] r_plus3;

  always_ff @(posedge clock) begin
    if (!reset_n)                                    r_plus3 <= c_rst_plus3;
    else if (w_io_evt && w_hit_1ffd && !r_cfg_locked) r_plus3 <= io_data[2:0];
  end

  assign w_rom_hi      = c_rom4 & r_plus3[2];
  assign w_special     = r_plus3[0];
  assign w_special_sel = r_plus3[2:1];
`else
  assign w_rom_hi      = 1'b0;
  assign w_special     = 1'b0;
  assign w_special_sel = 2'b00;
`endif

  assign w_rom_sel = {w_rom_hi, r_rom_lo};

  always_comb begin
    w_is_rom = 1'b0;
    w_idx    = 6'd0;
    if (w_special) begin
      case (w_special_sel)
        2'd0: w_idx = {4'd0, cpu_addr[15:14]};
        2'd1: w_idx = {4'd1, cpu_addr[15:14]};
        2'd2: w_idx = (cpu_addr[15:14] == 2'd3) ? 6'd3 : {4'd1, cpu_addr[15:14]};
        default: begin
          case (cpu_addr[15:14])
            2'd0:    w_idx = 6'd4;
            2'd1:    w_idx = 6'd7;
            2'd2:    w_idx = 6'd6;
            default: w_idx = 6'd3;
          endcase
        end
      endcase
    end else begin
      case (cpu_addr[15:14])
        2'd0: begin
          w_is_rom = 1'b1;
          w_idx    = {4'd0, w_rom_sel};
        end
        2'd1:    w_idx = c_ram_screen0;
        2'd2:    w_idx = c_ram_slot2;
        default: w_idx = {1'b0, r_ram_sel};
      endcase
    end
  end

  assign w_page      = phys_page(w_is_rom, w_idx, ROM_PAGES);
  assign w_vid_page  = phys_page(1'b0, r_screen ? c_ram_screen1 : c_ram_screen0, ROM_PAGES);
  assign w_full_addr = {w_page, cpu_addr[13:0]};
  assign w_full_vid  = {w_vid_page, 1'b0, vid_addr};

  assign mem_addr     = w_full_addr[PHYS_W-1:0];
  assign mem_wren     = cpu_wren & ~w_is_rom;
  assign vid_mem_addr = w_full_vid[PHYS_W-1:0];
  assign border       = r_border;
  assign cfg_locked   = r_cfg_locked;

endmodule
`default_nettype wire

// File: tb/tb_zx_mmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_zx_mmu
// Brief    : Directed self-checking bench for zx_mmu (8-page and 32-page RAM).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zx_mmu;

  logic        clock;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_wren;
  logic [15:0] io_addr;
  logic [7:0]  io_data;
  logic        io_wren;
  logic [12:0] vid_addr;
  logic [17:0] mem_addr;
  logic        mem_wren;
  logic [17:0] vid_mem_addr;
  logic [2:0]  border;
  logic        cfg_locked;
  logic [19:0] mem_addr32;
  logic        mem_wren32;
  logic [19:0] vid_mem_addr32;
  logic [2:0]  border32;
  logic        cfg_locked32;

  int n_pass;
  int n_total;

  zx_mmu #(.ROM_PAGES(2), .RAM_PAGES(8), .PHYS_W(18)) u_dut (
    .clock(clock), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .io_addr(io_addr), .io_data(io_data), .io_wren(io_wren), .vid_addr(vid_addr),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .vid_mem_addr(vid_mem_addr),
    .border(border), .cfg_locked(cfg_locked)
  );

  zx_mmu #(.ROM_PAGES(2), .RAM_PAGES(32), .PHYS_W(20)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .io_addr(io_addr), .io_data(io_data), .io_wren(io_wren), .vid_addr(vid_addr),
    .mem_addr(mem_addr32), .mem_wren(mem_wren32), .vid_mem_addr(vid_mem_addr32),
    .border(border32), .cfg_locked(cfg_locked32)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic io_out(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    io_addr = a;
    io_data = d;
    io_wren = 1'b1;
    @(negedge clock);
    io_wren = 1'b0;
  endtask

  task automatic probe(input logic [15:0] a, input logic w);
    cpu_addr = a;
    cpu_wren = w;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vid_addr = 13'h0000;
    probe(16'h0123, 1'b0);
    n_total++; if (mem_addr !== 18'h00123) $display("FAIL rst_addr got %h exp %h", mem_addr, 18'h00123); else n_pass++;
    n_total++; if (mem_wren !== 1'b0) $display("FAIL rst_wren_rd got %b exp 0", mem_wren); else n_pass++;
    n_total++; if (border !== 3'd0) $display("FAIL rst_border got %0d exp 0", border); else n_pass++;
    n_total++; if (cfg_locked !== 1'b0) $display("FAIL rst_lock got %b exp 0", cfg_locked); else n_pass++;
    n_total++; if (vid_mem_addr !== 18'h1C000) $display("FAIL rst_vid got %h exp %h", vid_mem_addr, 18'h1C000); else n_pass++;
    probe(16'h0123, 1'b1);
    n_total++; if (mem_wren !== 1'b0) $display("FAIL rom_write_blocked got %b exp 0", mem_wren); else n_pass++;
  endtask

  task automatic test_fixed_slots();
    probe(16'h4000, 1'b1);
    n_total++; if (mem_addr !== 18'h1C000) $display("FAIL slot1_addr got %h exp %h", mem_addr, 18'h1C000); else n_pass++;
    n_total++; if (mem_wren !== 1'b1) $display("FAIL slot1_wren got %b exp 1", mem_wren); else n_pass++;
    probe(16'hBFFF, 1'b0);
    n_total++; if (mem_addr !== 18'h13FFF) $display("FAIL slot2_top got %h exp %h", mem_addr, 18'h13FFF); else n_pass++;
    vid_addr = 13'h1FFF;
    #1;
    n_total++; if (vid_mem_addr !== 18'h1DFFF) $display("FAIL vid_top got %h exp %h", vid_mem_addr, 18'h1DFFF); else n_pass++;
    vid_addr = 13'h0000;
  endtask

  task automatic test_ram_page();
    @(negedge clock);
    io_addr = 16'h7FFD;
    io_data = 8'h03;
    io_wren = 1'b1;
    probe(16'hC000, 1'b1);
    n_total++; if (mem_addr !== 18'h08000) $display("FAIL page_before_edge got %h exp %h", mem_addr, 18'h08000); else n_pass++;
    @(negedge clock);
    io_wren = 1'b0;
    #1;
    n_total++; if (mem_addr !== 18'h14000) $display("FAIL page3_addr got %h exp %h", mem_addr, 18'h14000); else n_pass++;
    n_total++; if (mem_wren !== 1'b1) $display("FAIL page3_wren got %b exp 1", mem_wren); else n_pass++;
  endtask

  task automatic test_rom_screen();
    io_out(16'h7FFD, 8'h18);
    probe(16'h0000, 1'b1);
    n_total++; if (mem_addr !== 18'h04000) $display("FAIL rom1_addr got %h exp %h", mem_addr, 18'h04000); else n_pass++;
    n_total++; if (mem_wren !== 1'b0) $display("FAIL rom1_wren got %b exp 0", mem_wren); else n_pass++;
    n_total++; if (vid_mem_addr !== 18'h24000) $display("FAIL screen1_vid got %h exp %h", vid_mem_addr, 18'h24000); else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    io_out(16'h7FFD, 8'h20);
    #1;
    n_total++; if (cfg_locked !== 1'b1) $display("FAIL lock_set got %b exp 1", cfg_locked); else n_pass++;
    io_out(16'h7FFD, 8'h07);
    probe(16'hC000, 1'b0);
    n_total++; if (mem_addr !== 18'h08000) $display("FAIL lock_holds got %h exp %h", mem_addr, 18'h08000); else n_pass++;
    io_out(16'h00FE, 8'h05);
    #1;
    n_total++; if (border !== 3'd5) $display("FAIL border_locked got %0d exp 5", border); else n_pass++;
    do_reset();
    #1;
    n_total++; if (cfg_locked !== 1'b0) $display("FAIL lock_cleared got %b exp 0", cfg_locked); else n_pass++;
    n_total++; if (border !== 3'd0) $display("FAIL border_cleared got %0d exp 0", border); else n_pass++;
  endtask

  task automatic test_overlap();
    io_out(16'h7FFC, 8'h06);
    probe(16'hC000, 1'b0);
    n_total++; if (border !== 3'd6) $display("FAIL overlap_border got %0d exp 6", border); else n_pass++;
    n_total++; if (mem_addr !== 18'h20000) $display("FAIL overlap_page got %h exp %h", mem_addr, 18'h20000); else n_pass++;
  endtask

  task automatic test_long_strobe();
    do_reset();
    @(negedge clock);
    io_addr = 16'h7FFD;
    io_data = 8'h01;
    io_wren = 1'b1;
    repeat (4) @(negedge clock);
    io_data = 8'h02;
    repeat (6) @(negedge clock);
    io_wren = 1'b0;
    @(negedge clock);
    probe(16'hC000, 1'b0);
    n_total++; if (mem_addr !== 18'h0C000) $display("FAIL long_strobe got %h exp %h", mem_addr, 18'h0C000); else n_pass++;
  endtask

  task automatic test_reset_mid_strobe();
    @(negedge clock);
    io_addr = 16'h7FFD;
    io_data = 8'h04;
    io_wren = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    probe(16'hC000, 1'b0);
    n_total++; if (mem_addr !== 18'h08000) $display("FAIL in_reset_page got %h exp %h", mem_addr, 18'h08000); else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    n_total++; if (mem_addr !== 18'h18000) $display("FAIL post_reset_edge got %h exp %h", mem_addr, 18'h18000); else n_pass++;
    io_wren = 1'b0;
  endtask

  task automatic test_ram32();
    do_reset();
    io_out(16'h7FFD, 8'hC1);
    probe(16'hC000, 1'b1);
    n_total++; if (mem_addr32 !== 20'h6C000) $display("FAIL ram32_page25 got %h exp %h", mem_addr32, 20'h6C000); else n_pass++;
    n_total++; if (mem_wren32 !== 1'b1) $display("FAIL ram32_wren got %b exp 1", mem_wren32); else n_pass++;
    n_total++; if (mem_addr !== 18'h0C000) $display("FAIL ram8_ignores_hi got %h exp %h", mem_addr, 18'h0C000); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_wren = 1'b0;
    io_addr  = 16'hFFFF;
    io_data  = 8'h00;
    io_wren  = 1'b0;
    vid_addr = 13'h0000;
    test_reset();
    test_fixed_slots();
    test_ram_page();
    test_rom_screen();
    test_lock();
    test_overlap();
    test_long_strobe();
    test_reset_mid_strobe();
    test_ram32();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
